// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: 2-entry skid buffer that reads fifo_sync (1-cycle rdata latency)
// and presents a valid/ready stream with a synchronous flush.
// Optional transfer counter xfer_cnt is built only when FIFO_READER_CNT_EN is defined.
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_rvalid,
    input  logic              flush,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
`ifdef FIFO_READER_CNT_EN
   ,output logic [CNT_W-1:0]  xfer_cnt
`endif
);
    logic [DATA_W-1:0] mem [2];
    logic [1:0]        cnt;
    logic              rd_ptr;
    logic              wr_ptr;
    logic              push;
    logic              pop;

    // Handshake and read-ahead: a read is issued only if the word it returns is sure to fit.
    always_comb begin
        m_valid  = (cnt != 2'd0) & ~flush;
        m_data   = mem[rd_ptr];
        pop      = m_valid & m_ready;
        push     = fifo_rvalid & ~flush;
        fifo_ren = rst_n & ~flush & ~fifo_empty & ((cnt + {1'b0, fifo_rvalid} < 2'd2) | pop);
    end

    // Buffer storage, pointers and occupancy; flush empties the buffer and drops the arriving word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (flush) begin
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) mem[wr_ptr] <= fifo_rdata;
            cnt    <= cnt + {1'b0, push} - {1'b0, pop};
            rd_ptr <= rd_ptr ^ pop;
            wr_ptr <= wr_ptr ^ push;
        end
    end

    // The read-ahead rule must never let a returning word land in a full buffer.
    always @(posedge clk) begin
        if (rst_n && !flush) assert (cnt + {1'b0, push} - {1'b0, pop} <= 2'd2);
    end

`ifdef FIFO_READER_CNT_EN
    // Accepted-transfer counter; wraps naturally and survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt <= '0;
        else if (pop) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: drives fifo_stream_reader from a behavioural fifo_sync and
// checks it against a queue model of the words the reader holds.
module tb_fifo_stream_reader;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              fifo_empty = 1'b1;
    logic              fifo_ren;
    logic [DATA_W-1:0] fifo_rdata = '0;
    logic              fifo_rvalid = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
`ifdef FIFO_READER_CNT_EN
    logic [CNT_W-1:0]  xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] bq[$];
    logic [DATA_W-1:0] out_q[$];
    int out_cyc[$];
    int cyc = 0;
    int nren = 0;
    int first_ren = -1;
    int first_valid = -1;
    int dropped = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_empty(fifo_empty),
        .fifo_ren(fifo_ren),
        .fifo_rdata(fifo_rdata),
        .fifo_rvalid(fifo_rvalid),
        .flush(flush),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready)
`ifdef FIFO_READER_CNT_EN
       ,.xfer_cnt(xfer_cnt)
`endif
    );

    // Behavioural fifo_sync: read data one cycle after an accepted ren, writes at the edge.
    always @(posedge clk) begin
        if (fifo_ren && fq.size() > 0) begin
            fifo_rdata  <= fq.pop_front();
            fifo_rvalid <= 1'b1;
        end else begin
            fifo_rvalid <= 1'b0;
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    task automatic step(input logic rdy, input logic fl, input logic we, input logic [DATA_W-1:0] wd);
        int   outstanding;
        logic exp_valid;
        logic exp_ren;
        logic xfer;
        @(negedge clk);
        m_ready = rdy;
        flush   = fl;
        wr_en   = we;
        wr_data = wd;
        #1;
        cyc++;
        exp_valid   = (bq.size() != 0) && !fl;
        xfer        = exp_valid && rdy;
        outstanding = bq.size() + int'(fifo_rvalid);
        exp_ren     = !fl && !fifo_empty && (outstanding - int'(xfer) < 2);
        checks++;
        if (m_valid !== exp_valid) begin
            errors++;
            $display("FAIL m_valid cyc %0d got %b expected %b", cyc, m_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (m_data !== bq[0]) begin
                errors++;
                $display("FAIL m_data cyc %0d got %h expected %h", cyc, m_data, bq[0]);
            end
        end
        checks++;
        if (fifo_ren !== exp_ren) begin
            errors++;
            $display("FAIL fifo_ren cyc %0d got %b expected %b", cyc, fifo_ren, exp_ren);
        end
        if (fifo_ren === 1'b1) begin
            nren++;
            if (first_ren < 0) first_ren = cyc;
        end
        if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (fl) begin
            dropped += outstanding;
            bq.delete();
        end else begin
            if (xfer) begin
                out_q.push_back(bq.pop_front());
                out_cyc.push_back(cyc);
            end
            if (fifo_rvalid) bq.push_back(fifo_rdata);
        end
        checks++;
        if (bq.size() > 2) begin
            errors++;
            $display("FAIL occupancy cyc %0d got %0d expected <=2", cyc, bq.size());
        end
    endtask

    task automatic clear_log();
        out_q.delete();
        out_cyc.delete();
        nren = 0;
        first_ren = -1;
        first_valid = -1;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            step(1'b1, 1'b0, 1'b0, '0);
            n++;
        end while (!(fifo_empty && fifo_ren === 1'b0 && bq.size() == 0) && n < 200);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain timeout got %0d cycles expected <200", n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b expected 0", m_valid); end
        if (fifo_ren !== 1'b0) begin errors++; $display("FAIL reset_fifo_ren got %b expected 0", fifo_ren); end
        if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got %h expected 00", m_data); end
        m_ready = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        bq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'h5A + 8'(i));
        repeat (2) step(1'b1, 1'b0, 1'b0, '0);
        do_reset();
        clear_log();
    endtask

    task automatic test_stream();
        drain();
        clear_log();
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b1, 8'(i));
        repeat (22) step(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (out_q.size() != 16) begin
            errors++;
            $display("FAIL stream_count got %0d expected 16", out_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (out_q[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL stream_data[%0d] got %h expected %h", i, out_q[i], 8'(i + 1));
                end
            end
            checks++;
            if (out_cyc[15] - out_cyc[0] != 15) begin
                errors++;
                $display("FAIL stream_span got %0d expected 15", out_cyc[15] - out_cyc[0]);
            end
        end
        checks++;
        if (first_valid - first_ren != 2) begin
            errors++;
            $display("FAIL stream_latency got %0d expected 2", first_valid - first_ren);
        end
    endtask

    task automatic test_backpressure();
        drain();
        clear_log();
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b1, 8'(i));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            if (i >= 2) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 8'h01) begin
                    errors++;
                    $display("FAIL stall_hold got %b/%h expected 1/01", m_valid, m_data);
                end
            end
        end
        checks++;
        if (nren != 2) begin
            errors++;
            $display("FAIL stall_ren got %0d expected 2", nren);
        end
        repeat (12) step(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (out_q.size() != 5) begin
            errors++;
            $display("FAIL stall_count got %0d expected 5", out_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (out_q[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL stall_data[%0d] got %h expected %h", i, out_q[i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_flush();
        drain();
        clear_log();
        step(1'b0, 1'b1, 1'b1, 8'hA0);
        step(1'b0, 1'b1, 1'b1, 8'hA1);
        repeat (2) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 8'hA2);
        step(1'b0, 1'b1, 1'b1, 8'hA3);
        repeat (4) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid got %b expected 0", m_valid);
        end
        step(1'b1, 1'b0, 1'b1, 8'hB0);
        repeat (6) step(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== 8'hB0) begin
            errors++;
            $display("FAIL flush_next got %0d words first %h expected 1 word B0",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 8'h00);
        end
    endtask

    task automatic test_random();
        int written = 0;
        int guard = 0;
        int d0;
        drain();
        clear_log();
        d0 = dropped;
        while (written < 10000 && guard < 60000) begin
            logic we, rdy, fl;
            we  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 99) == 0);
            step(rdy, fl, we, 8'(written));
            if (we) written++;
            guard++;
        end
        drain();
        checks++;
        if (out_q.size() + (dropped - d0) != written) begin
            errors++;
            $display("FAIL random_conserve got %0d delivered+%0d dropped expected %0d",
                     out_q.size(), dropped - d0, written);
        end
        for (int i = 1; i < out_q.size(); i++) begin
            if (out_q[i] === out_q[i - 1]) begin
                checks++;
                errors++;
                $display("FAIL random_dup idx %0d got %h expected a new word", i, out_q[i]);
            end
        end
    endtask

`ifdef FIFO_READER_CNT_EN
    task automatic test_cnt();
        do_reset();
        clear_log();
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b1, 8'(i + 8'h40));
        repeat (22) step(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (out_q.size() != 17 || xfer_cnt !== 4'd1) begin
            errors++;
            $display("FAIL cnt_wrap got %0d after %0d transfers expected 1", xfer_cnt, out_q.size());
        end
        step(1'b0, 1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b1, 1'b1, 8'h78);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (xfer_cnt !== 4'd1) begin
            errors++;
            $display("FAIL cnt_flush got %0d expected 1", xfer_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_random();
`ifdef FIFO_READER_CNT_EN
        test_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
